// File: rtl/iq_power_avg_pkg.sv
// Width helpers shared by the power averager and the downstream sqrt pipe,
// so the radicand width always matches the averaged power width.
package iq_power_avg_pkg;

    // |x|^2 width for DATA_W-bit signed I/Q (also the sqrt radicand width)
    function automatic int pwr_w(input int d);
        return 2 * d;
    endfunction

    // accumulator width: 2^l sums of pwr_w bits can never overflow
    function automatic int acc_w(input int d, input int l);
        return 2 * d + l;
    endfunction

    // window counter width; one bit minimum so LOG2_LEN=0 stays legal
    function automatic int cnt_w(input int l);
        return (l > 0) ? l : 1;
    endfunction

endpackage

// File: rtl/iq_power_avg_if.sv
// Sample-in / mean-power-out bus of iq_power_avg.
interface iq_power_avg_if
    import iq_power_avg_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int LOG2_LEN = 2
);
    logic                           clear;
    logic                           in_valid;
    logic signed [DATA_W-1:0]       i_in;
    logic signed [DATA_W-1:0]       q_in;
    logic [pwr_w(DATA_W)-1:0]       pwr_out;
    logic                           pwr_valid;
    logic [cnt_w(LOG2_LEN)-1:0]     win_cnt;

    modport master (
        output clear, in_valid, i_in, q_in,
        input  pwr_out, pwr_valid, win_cnt
    );

    modport slave (
        input  clear, in_valid, i_in, q_in,
        output pwr_out, pwr_valid, win_cnt
    );
endinterface

// File: rtl/iq_sq_sum.sv
// S1/S2 of the power averager: registered I^2, Q^2, then their unsigned sum.
// clear flushes the in-flight valid bits so partial-window samples are dropped.
module iq_sq_sum
    import iq_power_avg_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic signed [DATA_W-1:0]    i_in,
    input  logic signed [DATA_W-1:0]    q_in,
    output logic [pwr_w(DATA_W)-1:0]    sum_out,
    output logic                        sum_valid
);
    localparam int PWR_W = pwr_w(DATA_W);
    localparam int SQ_W  = PWR_W - 1;

    logic signed [PWR_W-1:0] i_ext, q_ext, prod_i, prod_q;
    logic [SQ_W-1:0]         sq_i_q, sq_i_d, sq_q_q, sq_q_d;
    logic [PWR_W-1:0]        sum_q, sum_d;
    logic [1:0]              vld_q, vld_d;

    always_comb begin
        i_ext  = PWR_W'(i_in);
        q_ext  = PWR_W'(q_in);
        prod_i = i_ext * i_ext;
        prod_q = q_ext * q_ext;
        // squares are non-negative and at most 2^(2*DATA_W-2): top bit is always 0
        sq_i_d = prod_i[SQ_W-1:0];
        sq_q_d = prod_q[SQ_W-1:0];
        sum_d  = {1'b0, sq_i_q} + {1'b0, sq_q_q};
        vld_d  = {vld_q[0], in_valid};
        if (clear) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_i_q <= '0;
            sq_q_q <= '0;
            sum_q  <= '0;
            vld_q  <= '0;
        end else begin
            sq_i_q <= sq_i_d;
            sq_q_q <= sq_q_d;
            sum_q  <= sum_d;
            vld_q  <= vld_d;
        end
    end

    assign sum_out   = sum_q;
    assign sum_valid = vld_q[1];

endmodule

// File: rtl/iq_power_avg.sv
// Mean |I+jQ|^2 over windows of 2^LOG2_LEN valid samples; result held between
// windows so a stallable sqrt pipe can sample pwr_out whenever it is ready.
module iq_power_avg
    import iq_power_avg_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int LOG2_LEN = 2,
    parameter int ROUND    = 1
) (
    input  logic           clk,
    input  logic           rst,
    iq_power_avg_if.slave  bus
);
    localparam int PWR_W = pwr_w(DATA_W);
    localparam int ACC_W = acc_w(DATA_W, LOG2_LEN);
    localparam int CNT_W = cnt_w(LOG2_LEN);
    localparam int N     = 1 << LOG2_LEN;
    localparam logic [ACC_W-1:0] HALF = (ROUND != 0) ? ACC_W'(N / 2) : '0;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [PWR_W-1:0] sum;
    logic             sum_valid;

    iq_sq_sum #(.DATA_W(DATA_W)) u_sq_sum (
        .clk      (clk),
        .rst      (rst),
        .clear    (bus.clear),
        .in_valid (bus.in_valid),
        .i_in     (bus.i_in),
        .q_in     (bus.q_in),
        .sum_out  (sum),
        .sum_valid(sum_valid)
    );

    logic [ACC_W-1:0] acc_q, acc_d, total, mean;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PWR_W-1:0] pwr_q, pwr_d;
    logic             pv_q, pv_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        pwr_d = pwr_q;
        pv_d  = 1'b0;
        total = acc_q + ACC_W'(sum);
        // total + N/2 fits ACC_W and the shifted mean fits PWR_W: no saturation needed
        mean  = (total + HALF) >> LOG2_LEN;
        if (bus.clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (sum_valid) begin
            if (cnt_q == LAST) begin
                pwr_d = mean[PWR_W-1:0];
                pv_d  = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = total;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            pwr_q <= '0;
            pv_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            pwr_q <= pwr_d;
            pv_q  <= pv_d;
        end
    end

    assign bus.pwr_out   = pwr_q;
    assign bus.pwr_valid = pv_q;
    // with LOG2_LEN=0 the counter never leaves 0, so this is the required tie-off
    assign bus.win_cnt   = cnt_q;

endmodule
